// File: rtl/branch_seek_ctrl_pkg.sv
// Shared types and constants for the bracket-matching branch seeker.
package branch_seek_ctrl_pkg;

    // Seeker FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } seek_state_t;

    // Instruction word width on the memory read port.
    localparam int INSTR_W = 9;

    // Bracket instructions are full-word encodings with no operand field.
    localparam logic [INSTR_W-1:0] OP_OPEN  = 9'h1FE;
    localparam logic [INSTR_W-1:0] OP_CLOSE = 9'h1FF;

    // Seek direction encodings.
    localparam logic SEEK_FWD = 1'b0;
    localparam logic SEEK_BWD = 1'b1;

    // True when the instruction is an open bracket.
    function automatic logic is_open_op(input logic [INSTR_W-1:0] instr);
        return instr == OP_OPEN;
    endfunction

    // True when the instruction is a close bracket.
    function automatic logic is_close_op(input logic [INSTR_W-1:0] instr);
        return instr == OP_CLOSE;
    endfunction

endpackage

// File: rtl/branch_seek_ctrl_depth_ctr.sv
// Nesting-depth up/down counter. Flags report what the pending step would do:
// ovf_o when an increment would pass the maximum, zero_o when a decrement
// would bring the depth to zero. The count never underflows.
module bracket_depth_ctr #(
    parameter int DEPTH_W = 6
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic ovf_o,
    output logic zero_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    // Next depth and look-ahead flags.
    always_comb begin
        depth_d = depth_q;
        ovf_o   = 1'b0;
        zero_o  = 1'b0;
        if (load_i) begin
            depth_d = DEPTH_W'(1);
        end else if (inc_i && !dec_i) begin
            if (depth_q == DEPTH_MAX) begin
                ovf_o = 1'b1;
            end else begin
                depth_d = depth_q + DEPTH_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
                zero_o  = (depth_q == DEPTH_W'(1));
            end
        end
    end

    // Depth register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/branch_seek_ctrl.sv
// Bracket-matching branch seeker: walks instruction memory from a loop
// bracket, tracking nesting depth, and reports the matching bracket address
// to fetch and to the branch-target cache register.
module branch_seek_ctrl
    import branch_seek_ctrl_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DEPTH_W  = 6,
    parameter int MAX_SCAN = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dir,
    input  logic [PC_W-1:0]    start_pc,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    imem_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PC_W-1:0]    target_pc,
    output logic               cache_we,
    output logic [PC_W-1:0]    cache_wdata
);

    localparam int SCAN_W = $clog2(MAX_SCAN + 1);
    localparam logic [PC_W-1:0]   PC_LAST   = '1;
    localparam logic [SCAN_W-1:0] SCAN_STOP = SCAN_W'(MAX_SCAN);

    seek_state_t       state_q, state_d;
    logic              dir_q, dir_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic [SCAN_W-1:0] scan_q, scan_d;

    logic is_open, is_close;
    logic depth_load, depth_inc, depth_dec;
    logic depth_ovf, depth_zero;
    logic scan_last, at_edge;

    assign is_open  = is_open_op(imem_data);
    assign is_close = is_close_op(imem_data);

    // Forward seeks nest on opens; backward seeks nest on closes.
    assign depth_load = (state_q == IDLE) && start;
    assign depth_inc  = (state_q == CHECK) && ((dir_q == SEEK_FWD) ? is_open  : is_close);
    assign depth_dec  = (state_q == CHECK) && ((dir_q == SEEK_FWD) ? is_close : is_open);

    assign scan_last = (scan_q + SCAN_W'(1)) == SCAN_STOP;
    assign at_edge   = (dir_q == SEEK_FWD) ? (addr_q == PC_LAST) : (addr_q == '0);

    bracket_depth_ctr #(
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (depth_load),
        .inc_i   (depth_inc),
        .dec_i   (depth_dec),
        .ovf_o   (depth_ovf),
        .zero_o  (depth_zero)
    );

    // Next-state logic: accept start, step the address, resolve match/abort.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        addr_d   = addr_q;
        target_d = target_q;
        scan_d   = scan_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    scan_d  = '0;
                    addr_d  = (dir == SEEK_FWD) ? start_pc + PC_W'(1) : start_pc - PC_W'(1);
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = CHECK;
            end
            CHECK: begin
                scan_d = scan_q + SCAN_W'(1);
                // A match wins over every abort reason on the same cycle.
                if (depth_zero) begin
                    target_d = addr_q;
                    state_d  = DONE;
                end else if (depth_ovf || scan_last || at_edge) begin
                    state_d  = ERR;
                end else begin
                    addr_d  = (dir_q == SEEK_FWD) ? addr_q + PC_W'(1) : addr_q - PC_W'(1);
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= SEEK_FWD;
            addr_q   <= '0;
            target_q <= '0;
            scan_q   <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            scan_q   <= scan_d;
        end
    end

    assign imem_addr   = addr_q;
    assign busy        = (state_q == REQ) || (state_q == CHECK);
    assign done        = (state_q == DONE);
    assign err         = (state_q == ERR);
    assign target_pc   = target_q;
    assign cache_we    = (state_q == DONE);
    assign cache_wdata = target_q;

endmodule
